// File: rtl/counter_timer_ctrl.sv
// Programmable down-count timer: load/start/stop/clear commands, one-shot or periodic reload.
// Optional build macro COUNTER_PRESCALE_EN adds a prescale divider that paces the RUN-state ticks.
module counter_timer_ctrl #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef COUNTER_PRESCALE_EN
    input  logic [PRESCALE_W-1:0] prescale_i,
`endif
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic [WIDTH-1:0]      cmd_data_i,
    input  logic                  periodic_i,
    input  logic                  irq_ack_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  busy_o,
    output logic                  expire_o,
    output logic                  irq_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             irq_q, irq_d;
    logic             expire_q, expire_d;
    logic             accept;
    logic             tick;
    logic             div_clr;

`ifdef COUNTER_PRESCALE_EN
    logic [PRESCALE_W-1:0] div_q, div_d;

    assign tick = (div_q == prescale_i);

    always_comb begin
        div_d = tick ? '0 : div_q + 1'b1;
        if (state_q != S_RUN || div_clr)
            div_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) div_q <= '0;
        else         div_q <= div_d;
    end
`else
    assign tick = 1'b1;
`endif

    assign accept = cmd_valid_i && cmd_ready_o;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        irq_d    = irq_q;
        div_clr  = 1'b0;
        if (irq_ack_i)
            irq_d = 1'b0;
        case (state_q)
            S_IDLE, S_HOLD: begin
                if (accept) begin
                    case (cmd_op_i)
                        OP_LOAD: begin
                            reload_d = cmd_data_i;
                            count_d  = cmd_data_i;
                        end
                        OP_START: state_d = (count_q != '0) ? S_RUN : S_DONE;
                        OP_CLEAR: begin
                            state_d = S_IDLE;
                            count_d = '0;
                            irq_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (accept && cmd_op_i == OP_CLEAR) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    irq_d   = 1'b0;
                    div_clr = 1'b1;
                end else if (accept && cmd_op_i == OP_STOP) begin
                    state_d = S_HOLD;
                    div_clr = 1'b1;
                end else begin
                    if (accept && cmd_op_i == OP_LOAD)
                        reload_d = cmd_data_i;
                    if (accept && cmd_op_i == OP_START)
                        div_clr = 1'b1;
                    // Counter never wraps: zero is terminal until reload or a new LOAD.
                    if (tick && count_q != '0) begin
                        count_d = count_q - 1'b1;
                        if (count_q == WIDTH'(1))
                            state_d = S_DONE;
                    end
                end
            end
            default: begin
                div_clr = 1'b1;
                if (periodic_i && reload_q != '0) begin
                    count_d = reload_q;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
        // Expiry set takes priority over a same-cycle acknowledge.
        if (state_d == S_DONE)
            irq_d = 1'b1;
        expire_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            irq_q    <= 1'b0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            irq_q    <= irq_d;
            expire_q <= expire_d;
        end
    end

    assign cmd_ready_o = (state_q != S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign expire_o    = expire_q;
    assign irq_o       = irq_q;
    assign count_o     = count_q;

endmodule
